// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state encodings and nibble width for the serial adder
package nibble_serial_adder_pkg;
  localparam int NIB = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: start/busy/done operand bus; sub exists only with NSA_SUB_EN
interface nibble_serial_adder_if import nibble_serial_adder_pkg::*; #(parameter int WORDS = 4);
  logic start;
  logic [NIB*WORDS-1:0] a;
  logic [NIB*WORDS-1:0] b;
  logic cin;
`ifdef NSA_SUB_EN
  logic sub;
`endif
  logic busy;
  logic done;
  logic [NIB*WORDS-1:0] sum;
  logic cout;
  logic ovf;
  modport master(
`ifdef NSA_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input busy, done, sum, cout, ovf
  );
  modport slave(
`ifdef NSA_SUB_EN
    input sub,
`endif
    input start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/FA_4bit.sv
// FA_4bit: 4-bit ripple-carry adder
module FA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WORDS x 4-bit add over one shared FA_4bit, LSB nibble first.
// Define NSA_SUB_EN to add the sub port (A-B via inverted B and forced carry-in).
module nibble_serial_adder import nibble_serial_adder_pkg::*; #(
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst,
  nibble_serial_adder_if.slave bus
);
  localparam int W = NIB * WORDS;
  localparam logic [3:0] LAST = 4'(WORDS - 1);
  state_t state;
  logic [3:0] idx;
  logic carry, busy_r, done_r, cout_r, ovf_r;
  logic [W-1:0] a_reg, b_reg, sum_r;
  logic [NIB-1:0] an, bn, sn;
  logic co, accept;
`ifdef NSA_SUB_EN
  logic sub_reg;
  assign bn = b_reg[idx*NIB +: NIB] ^ {NIB{sub_reg}};
`else
  assign bn = b_reg[idx*NIB +: NIB];
`endif
  assign an = a_reg[idx*NIB +: NIB];
  assign accept = bus.start && state != RUN;
  FA_4bit u_fa (.a(an), .b(bn), .cin(carry), .sum(sn), .cout(co));
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      sum_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
`ifdef NSA_SUB_EN
      sub_reg <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        state  <= RUN;
        busy_r <= 1'b1;
        a_reg  <= bus.a;
        b_reg  <= bus.b;
        idx    <= '0;
        sum_r  <= '0;
`ifdef NSA_SUB_EN
        sub_reg <= bus.sub;
        carry   <= bus.sub | bus.cin;
`else
        carry <= bus.cin;
`endif
      end else if (state == RUN) begin
        sum_r[idx*NIB +: NIB] <= sn;
        carry <= co;
        if (idx == LAST) begin
          state  <= DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          cout_r <= co;
          ovf_r  <= an[NIB-1] ^ bn[NIB-1] ^ sn[NIB-1] ^ co;
        end else begin
          idx <= idx + 4'd1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: scoreboard bench for nibble_serial_adder (WORDS=4); sub test needs NSA_SUB_EN
module tb_nibble_serial_adder;
  localparam int W = 16;
  typedef struct packed {
    logic [W-1:0] sum;
    logic cout;
    logic ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  nibble_serial_adder_if #(.WORDS(4)) bus ();
  nibble_serial_adder #(.WORDS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    logic [W-1:0] bb;
    logic [W:0] full;
    exp_t e;
    bb = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W + 1)'(sub ? 1'b1 : cin);
    e.sum = full[W-1:0];
    e.cout = full[W];
    e.ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: done=1 sum=%h with no expected result queued", bus.sum);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.sum, bus.cout, bus.ovf} !== {mon_e.sum, mon_e.cout, mon_e.ovf}) begin
          fails++;
          $display("FAIL result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                   bus.sum, bus.cout, bus.ovf, mon_e.sum, mon_e.cout, mon_e.ovf);
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
`ifdef NSA_SUB_EN
    bus.sub = sub;
`endif
    bus.start = 1'b1;
    sb.push_back(model(a, b, cin, sub));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                        output int lat, output int busy_cnt);
    drive(a, b, cin, sub);
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
`ifdef NSA_SUB_EN
    bus.sub = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      fails++;
      $display("FAIL reset_busy_done: got %b%b want 00", bus.busy, bus.done);
    end
    tests++;
    if ({bus.sum, bus.cout, bus.ovf} !== '0) begin
      fails++;
      $display("FAIL reset_result: got sum=%h cout=%b ovf=%b want all zero", bus.sum, bus.cout, bus.ovf);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_add;
    int lat, bc, bad;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, bc);
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL add_latency: got %0d want 5", lat);
    end
    tests++;
    if (bc !== 4) begin
      fails++;
      $display("FAIL add_busy_cycles: got %0d want 4", bc);
    end
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc);
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if ({bus.done, bus.busy, bus.sum, bus.cout, bus.ovf} !== {2'b00, 16'h0000, 1'b1, 1'b0}) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hold_after_done: %0d cycles wrong, want done=0 busy=0 sum=0000 cout=1 ovf=0 held", bad);
    end
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bc);
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL ovf_latency: got %0d want 5", lat);
    end
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, lat, bc);
  endtask

  task automatic test_ignore_start;
    int dones;
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.a = 16'hAAAA;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    tests++;
    if (dones !== 1) begin
      fails++;
      $display("FAIL ignore_start_dones: got %0d done pulses want 1", dones);
    end
  endtask

  task automatic test_abort;
    int dones, lat, bc;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.busy, bus.done, bus.sum} !== {2'b00, 16'h0000}) begin
      fails++;
      $display("FAIL abort_state: got busy=%b done=%b sum=%h want 0 0 0000", bus.busy, bus.done, bus.sum);
    end
    dones = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
    end
    run_op(16'h000F, 16'h0001, 1'b0, 1'b0, lat, bc);
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL after_abort_latency: got %0d want 5", lat);
    end
  endtask

  task automatic test_back_to_back;
    int t1, gap;
    logic busy_next;
    drive(16'h0102, 16'h0304, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.a = 16'hF00D;
    bus.b = 16'h1234;
    bus.cin = 1'b1;
    sb.push_back(model(16'hF00D, 16'h1234, 1'b1, 1'b0));
    t1 = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        t1 = n;
        break;
      end
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    gap = -1;
    busy_next = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) busy_next = bus.busy;
      if (bus.done === 1'b1) begin
        gap = n;
        break;
      end
    end
    tests++;
    if (t1 !== 5 || gap !== 5) begin
      fails++;
      $display("FAIL back_to_back_timing: got first=%0d gap=%0d want 5 and 5", t1, gap);
    end
    tests++;
    if (busy_next !== 1'b1) begin
      fails++;
      $display("FAIL back_to_back_no_idle: busy after DONE got %b want 1", busy_next);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef NSA_SUB_EN
  task automatic test_sub;
    int lat, bc;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, bc);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat, bc);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, bc);
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL sub_latency: got %0d want 5", lat);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_ignore_start();
    test_abort();
    test_back_to_back();
`ifdef NSA_SUB_EN
    test_sub();
`endif
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results never produced, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
